// File: rtl/tomasulo_pkg.sv
// -----------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo core: default tag/result widths,
// functional-unit requester indices and the common-data-bus record.
// No ports (package).
// -----------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int TAG_W  = 3;    // ROB index width (8-entry ROB)
    localparam int DATA_W = 16;   // result width

    // Requester indices on the CDB
    localparam logic [1:0] FU_ADD = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_BCH = 2'd2;

    // One broadcast on the common data bus
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic [1:0]        src;
    } cdb_bus_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Scans req starting at index ptr,
// wrapping modulo N, and returns a one-hot grant for the first set bit
// (all zero when req is empty). Shared by CDB arbitration and RS dispatch.
//
// Ports:
//   req   in  [N-1:0]      request vector
//   ptr   in  [PTR_W-1:0]  highest-priority index this cycle
//   grant out [N-1:0]      one-hot grant, never set for a non-requesting bit
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common-data-bus scheduler: grants one result producer (add, mul, branch)
// per cycle by round-robin and registers the winner's ROB tag and result
// onto the CDB, which the ROB and reservation stations snoop.
//
// Optional feature macro: CDB_AGE_GUARD_EN
//   When defined, per-requester saturating wait counters override the
//   round-robin order once any reaches AGE_MAX (lowest aged index wins), and
//   the aged_grant output flags the cycle after such an override grant.
//
// Ports:
//   clk1       in   core clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]         requester has a result
//   req_tag    in   [NUM_REQ*TAG_W]   packed ROB tags
//   req_data   in   [NUM_REQ*DATA_W]  packed results
//   req_ready  out  [NUM_REQ]         one-hot combinational grant
//   cdb_hold   in   ROB back-pressure: no grant, CDB outputs hold
//   flush      in   mispredict flush: no grant, broadcast dropped
//   cdb_valid  out  registered broadcast valid
//   cdb_tag    out  registered broadcast tag
//   cdb_data   out  registered broadcast value
//   cdb_src    out  registered granted requester index
//   aged_grant out  (CDB_AGE_GUARD_EN only) previous grant was an override
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 16
`ifdef CDB_AGE_GUARD_EN
    ,
    parameter int AGE_MAX = 4
`endif
) (
    input  logic                      clk1,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      cdb_hold,
    input  logic                      flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [1:0]                cdb_src
`ifdef CDB_AGE_GUARD_EN
    ,
    output logic                      aged_grant
`endif
);

    import tomasulo_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   win;
    logic               transfer;
    logic               allow;
    cdb_bus_t           bus_p1;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    // Grant is suppressed in reset as well as on flush/hold.
    assign allow = rst_n & ~flush & ~cdb_hold;

`ifdef CDB_AGE_GUARD_EN
    localparam int AGE_W = $clog2(AGE_MAX) + 1;

    logic [AGE_W-1:0]   age [NUM_REQ];
    logic [NUM_REQ-1:0] aged;
    logic [NUM_REQ-1:0] aged_pick;
    logic               aged_found;
    logic               override;
    logic               aged_p1;

    // Counters are registered, so gate with the live valid to never grant
    // a requester that has just dropped its request.
    always_comb begin
        aged       = '0;
        aged_pick  = '0;
        aged_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aged[i] = req_valid[i] && (age[i] >= AGE_W'(AGE_MAX));
            if (!aged_found && aged[i]) begin
                aged_pick[i] = 1'b1;
                aged_found   = 1'b1;
            end
        end
    end

    assign override = |aged;
    assign grant    = allow ? (override ? aged_pick : rr_grant) : '0;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) age[i] <= '0;
            aged_p1 <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || grant[i])
                    age[i] <= '0;
                else if (age[i] != '1)
                    age[i] <= age[i] + 1'b1;
            end
            aged_p1 <= transfer & override;
        end
    end

    assign aged_grant = aged_p1;
`else
    assign grant = allow ? rr_grant : '0;
`endif

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) win = PTR_W'(i);
    end

    // ---- grant -> CDB register stage (p1) ----
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            bus_p1     <= '0;
            bus_p1.src <= FU_ADD;
            rr_ptr     <= '0;
        end else if (flush) begin
            bus_p1.valid <= 1'b0;
        end else if (!cdb_hold) begin
            if (transfer) begin
                bus_p1.valid <= 1'b1;
                bus_p1.tag   <= req_tag[int'(win)*TAG_W +: TAG_W];
                bus_p1.data  <= req_data[int'(win)*DATA_W +: DATA_W];
                bus_p1.src   <= 2'(win);
                rr_ptr       <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            end else begin
                bus_p1.valid <= 1'b0;
            end
        end
        // cdb_hold without flush: broadcast and pointer re-presented unchanged
    end

    assign cdb_valid = bus_p1.valid;
    assign cdb_tag   = bus_p1.tag;
    assign cdb_data  = bus_p1.data;
    assign cdb_src   = bus_p1.src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed testbench for cdb_arbiter with hand-computed expected values.
// With CDB_AGE_GUARD_EN defined the DUT is built with AGE_MAX=2 and the
// override sequence is exercised as well.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 16;

    logic                      clk1 = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_hold;
    logic                      flush;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [1:0]                cdb_src;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk1 = ~clk1;

`ifdef CDB_AGE_GUARD_EN
    logic aged_grant;

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .AGE_MAX (2)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cdb_hold   (cdb_hold),
        .flush      (flush),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .cdb_src    (cdb_src),
        .aged_grant (aged_grant)
    );
`else
    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_hold  (cdb_hold),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_cdb(input string name, input int v, input int t, input int d, input int s);
        check({name, "_vld"},  32'(cdb_valid), 32'(v));
        check({name, "_tag"},  32'(cdb_tag),   32'(t));
        check({name, "_data"}, 32'(cdb_data),  32'(d));
        check({name, "_src"},  32'(cdb_src),   32'(s));
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic smp();
        @(negedge clk1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_tag   = '0;
        req_data  = '0;
        cdb_hold  = 1'b0;
        flush     = 1'b0;

        // Reset state, requests present but no grant while in reset
        #12;
        check_cdb("reset", 0, 0, 0, 0);
        check("reset_ready", 32'(req_ready), 32'h0);
`ifdef CDB_AGE_GUARD_EN
        check("reset_aged", 32'(aged_grant), 32'h0);
`endif
        req_valid = '0;
        smp();
        rst_n = 1'b1;

        // Single mul request
        step();
        set_req(1, 3'd5, 16'h00A3);
        req_valid = 3'b010;
        smp();
        check("single_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        smp();
        check_cdb("single_cdb", 1, 5, 16'h00A3, 1);
        check("single_ready_off", 32'(req_ready), 32'h0);
        step();
        smp();
        check("idle_vld", 32'(cdb_valid), 32'h0);
        check("idle_tag_kept", 32'(cdb_tag), 32'h5);

        // All three valid from reset: add, mul, bch, add, ...
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_req(0, 3'd1, 16'h1111);
        set_req(1, 3'd2, 16'h2222);
        set_req(2, 3'd3, 16'h3333);
        req_valid = 3'b111;
        #1;
        for (int c = 0; c < 6; c++) begin
            check("rot_ready", 32'(req_ready), 32'(1 << (c % 3)));
            if (c > 0) begin
                check("rot_src", 32'(cdb_src), 32'((c - 1) % 3));
                check("rot_tag", 32'(cdb_tag), 32'((c - 1) % 3 + 1));
            end
            step();
            smp();
        end
        check_cdb("rot_last", 1, 3, 16'h3333, 2);

        // Broadcast tag 3 / 1234 from add, then two hold cycles
        step();
        req_valid = 3'b001;
        set_req(0, 3'd3, 16'h1234);
        smp();
        check("hold_pre_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b110;
        set_req(1, 3'd6, 16'h5555);
        set_req(2, 3'd4, 16'h4444);
        cdb_hold = 1'b1;
        smp();
        check("hold1_ready", 32'(req_ready), 32'h0);
        check_cdb("hold1_cdb", 1, 3, 16'h1234, 0);
        step();
        smp();
        check("hold2_ready", 32'(req_ready), 32'h0);
        check_cdb("hold2_cdb", 1, 3, 16'h1234, 0);
        step();
        cdb_hold = 1'b0;
        smp();
        check("hold_rel_ready", 32'(req_ready), 32'h2);
        check_cdb("hold_rel_cdb", 1, 3, 16'h1234, 0);

        // Flush together with hold and a pending add request
        step();
        req_valid = 3'b101;
        flush = 1'b1;
        cdb_hold = 1'b1;
        smp();
        check_cdb("pre_flush_cdb", 1, 6, 16'h5555, 1);
        check("flush_ready", 32'(req_ready), 32'h0);
        step();
        flush = 1'b0;
        cdb_hold = 1'b0;
        req_valid = 3'b111;
        smp();
        check("flush_vld", 32'(cdb_valid), 32'h0);
        check("flush_ptr_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = 3'b001;
        smp();
        check_cdb("post_flush_cdb", 1, 4, 16'h4444, 2);
        check("post_flush_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b111;
        smp();
        check_cdb("add_cdb", 1, 3, 16'h1234, 0);

        // Asynchronous reset mid-cycle while a broadcast is valid (ptr is 1 here)
        #1;
        rst_n = 1'b0;
        #1;
        check("async_vld", 32'(cdb_valid), 32'h0);
        check("async_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check("async_first_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        smp();
        check_cdb("async_first_cdb", 1, 3, 16'h1234, 0);
        step();
        smp();
        check("async_idle_vld", 32'(cdb_valid), 32'h0);

`ifdef CDB_AGE_GUARD_EN
        // ptr is 1: round-robin alone would pick bch, the age override picks add
        step();
        set_req(0, 3'd2, 16'h0AAA);
        set_req(2, 3'd7, 16'h0BBB);
        req_valid = 3'b101;
        cdb_hold = 1'b1;
        smp();
        step();
        smp();
        check("age_hold_ready", 32'(req_ready), 32'h0);
        check("age_hold_flag", 32'(aged_grant), 32'h0);
        step();
        cdb_hold = 1'b0;
        smp();
        check("age_override_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 3'b100;
        smp();
        check("age_flag", 32'(aged_grant), 32'h1);
        check_cdb("age_cdb", 1, 2, 16'h0AAA, 0);
        check("age_next_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        smp();
        check_cdb("age_bch_cdb", 1, 7, 16'h0BBB, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
